sdram_pack_fifo: RTL

SDRAM_PACK_FIFO -- requirements
Module: sdram_pack_fifo

---
 rtl/sdram_pack_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sdram_pack_fifo.sv
// Packs narrow system-side beats into SDRAM-width words and buffers them in a FWFT FIFO.
// Define SDRAM_PACK_BE_EN to store a per-lane valid mask with each word and expose it on sdr_be.
module sdram_pack_fifo #(
    parameter int SYS_BUSWIDTH = 8,
    parameter int SDR_BUSWIDTH = 32,
    parameter int BUF_DEPTH    = 64,
    parameter int BURST_LEN    = 8
) (
    input  logic                                    sys_clk,
    input  logic                                    sys_rst,
    input  logic [SYS_BUSWIDTH-1:0]                 sys_datai,
    input  logic                                    sys_valid,
    output logic                                    sys_ready,
    input  logic                                    sys_flush,
    output logic [SDR_BUSWIDTH-1:0]                 sdr_datao,
    output logic                                    sdr_valid,
    input  logic                                    sdr_ready,
`ifdef SDRAM_PACK_BE_EN
    output logic [SDR_BUSWIDTH/SYS_BUSWIDTH-1:0]    sdr_be,
`endif
    output logic [$clog2(BUF_DEPTH):0]              level,
    output logic                                    burst_rdy
);

    localparam int RATIO = SDR_BUSWIDTH / SYS_BUSWIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int LVW   = $clog2(BUF_DEPTH) + 1;

    logic [SDR_BUSWIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           pack_cnt;
    logic [SDR_BUSWIDTH-1:0] pack_reg;
    logic [SDR_BUSWIDTH-1:0] push_word;
    logic [LVW-1:0]          level_nxt;
    logic                    accept;
    logic                    full;
    logic                    last_lane;
    logic                    word_done;
    logic                    flush_ok;
    logic                    push;
    logic                    pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(BUF_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // sys_ready only looks at registered state, so a same-cycle pop never frees a slot
    assign full      = (level == LVW'(BUF_DEPTH));
    assign last_lane = (pack_cnt == CW'(RATIO - 1));
    assign sys_ready = !(full && last_lane);
    assign accept    = sys_valid && sys_ready;
    assign word_done = accept && last_lane;
    assign flush_ok  = sys_flush && (pack_cnt != '0) && !full;
    assign push      = word_done || flush_ok;
    assign pop       = sdr_ready && sdr_valid;

    assign sdr_valid = (level != '0);
    assign sdr_datao = mem[rd_ptr];

    always_comb begin
        push_word = pack_reg;
        if (accept) begin
            push_word[int'(pack_cnt)*SYS_BUSWIDTH +: SYS_BUSWIDTH] = sys_datai;
        end
    end

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LVW'(1);
            2'b01:   level_nxt = level - LVW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            pack_cnt <= '0;
            pack_reg <= '0;
        end else if (push) begin
            pack_cnt <= '0;
            pack_reg <= '0;
        end else if (accept) begin
            pack_cnt <= pack_cnt + CW'(1);
            pack_reg <= push_word;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            burst_rdy <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            level     <= level_nxt;
            burst_rdy <= (level_nxt >= LVW'(BURST_LEN));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

`ifdef SDRAM_PACK_BE_EN
    logic [RATIO-1:0] be_mem [BUF_DEPTH];
    logic [RATIO-1:0] push_be;
    logic [CW:0]      fill_cnt;

    // Flushed words mark only the lanes filled so far, including a same-cycle beat
    always_comb begin
        fill_cnt = {1'b0, pack_cnt} + (CW+1)'(accept);
        push_be  = '1;
        if (!word_done) begin
            for (int i = 0; i < RATIO; i++) begin
                push_be[i] = (i < int'(fill_cnt));
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) be_mem[wr_ptr] <= push_be;
    end

    assign sdr_be = sdr_valid ? be_mem[rd_ptr] : '0;
`endif

endmodule
